// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// Holds the loader state codes and the default word/address/depth sizes.
// Imported by the interface, the array and the loader top.
package imem_loader_pkg;

  localparam int D_WIDTH_DEF  = 32;
  localparam int SA_WIDTH_DEF = 5;
  localparam int IMEM_DEPTH   = 32;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LOAD  = 3'd1,
    LDR_START = 3'd2,
    LDR_RUN   = 3'd3,
    LDR_HALT  = 3'd4
  } ldr_state_e;

  // Loader is busy while a program is being loaded, started or executed.
  function automatic logic ldr_busy(input ldr_state_e s);
    return (s == LDR_LOAD) || (s == LDR_START) || (s == LDR_RUN);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between host/GPP side (master) and the instruction-memory loader (slave).
// Carries the load word stream, the GPP fetch port, core control and status.
// Purely wiring; no storage.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int SA_WIDTH = SA_WIDTH_DEF
) ();

  logic                LdValid;
  logic [D_WIDTH-1:0]  LdData;
  logic                LdLast;
  logic                LdReady;
  logic [SA_WIDTH-1:0] Addr;
  logic                En;
  logic                RW;
  logic [D_WIDTH-1:0]  Data;
  logic                CpuRst;
  logic                CpuDone;
  logic [SA_WIDTH:0]   WordCount;
  logic                Busy;
  logic                Halted;
  logic                Err;

  modport master (
    output LdValid, LdData, LdLast, Addr, En, RW, CpuDone,
    input  LdReady, Data, CpuRst, WordCount, Busy, Halted, Err
  );

  modport slave (
    input  LdValid, LdData, LdLast, Addr, En, RW, CpuDone,
    output LdReady, Data, CpuRst, WordCount, Busy, Halted, Err
  );

endinterface

// File: rtl/imem_loader_array.sv
// DEPTH x D_WIDTH word store: one synchronous write port, one registered read port.
// Read data appears one cycle after rd_en_i; rd_clr_i forces the read register to zero.
// No backpressure; contents are never cleared by reset.
module imem_array
  import imem_loader_pkg::*;
#(
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int SA_WIDTH = SA_WIDTH_DEF,
  parameter int DEPTH    = IMEM_DEPTH
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                wr_en_i,
  input  logic [SA_WIDTH-1:0] wr_addr_i,
  input  logic [D_WIDTH-1:0]  wr_dat_i,
  input  logic                rd_en_i,
  input  logic                rd_clr_i,
  input  logic [SA_WIDTH-1:0] rd_addr_i,
  output logic [D_WIDTH-1:0]  rd_dat_o
);

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [D_WIDTH-1:0] rd_dat_q;

  // Program words land here during loading; no reset so the program survives Rst.
  always_ff @(posedge Clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_dat_i;
    end
  end

  // Registered read: clear wins over a read, and the value holds when idle.
  always_ff @(posedge Clk) begin
    if (Rst || rd_clr_i) begin
      rd_dat_q <= '0;
    end else if (rd_en_i) begin
      rd_dat_q <= mem[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a program via valid/ready, holds the GPP in reset, then serves its fetches.
// Fetch latency 1 cycle (registered Data); load handshake is zero-latency on LdValid && LdReady.
// LdReady drops once the program is closed or the array is full; late LdValid is ignored.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int SA_WIDTH = SA_WIDTH_DEF,
  parameter int DEPTH    = IMEM_DEPTH
) (
  input  logic          Clk,
  input  logic          Rst,
  imem_loader_if.slave  bus
);

  localparam logic [SA_WIDTH:0] DEPTH_C = (SA_WIDTH + 1)'(DEPTH);

  ldr_state_e        state_q, state_d;
  logic [SA_WIDTH:0] wc_q, wc_d;
  logic              err_q, err_d;

  logic ld_rdy;
  logic ld_hs;
  logic run;
  logic fetch_rd;
  logic fetch_wr;
  logic in_range;
  logic rd_en;
  logic rd_clr;

  // Words are only taken while the program is still open and there is room.
  assign ld_rdy   = ((state_q == LDR_IDLE) || (state_q == LDR_LOAD)) && (wc_q < DEPTH_C);
  assign ld_hs    = bus.LdValid && ld_rdy;
  assign run      = (state_q == LDR_RUN);
  assign fetch_rd = run && bus.En && !bus.RW;
  assign fetch_wr = run && bus.En && bus.RW;
  // Fetches beyond the loaded program return an all-zero no-op.
  assign in_range = ({1'b0, bus.Addr} < wc_q);
  assign rd_en    = fetch_rd && in_range;
  assign rd_clr   = !run || (fetch_rd && !in_range);

  // Next-state, word counter and sticky error logic.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    err_d   = err_q;
    if (ld_hs) begin
      wc_d = wc_q + 1'b1;
    end
    if (fetch_wr) begin
      err_d = 1'b1;
    end
    case (state_q)
      LDR_IDLE, LDR_LOAD: begin
        if (ld_hs) begin
          if (bus.LdLast) begin
            state_d = LDR_START;
          end else if (wc_d == DEPTH_C) begin
            // Array filled without a final-word marker: run what we have, flag it.
            state_d = LDR_START;
            err_d   = 1'b1;
          end else begin
            state_d = LDR_LOAD;
          end
        end
      end
      LDR_START: state_d = LDR_RUN;
      LDR_RUN: begin
        if (bus.CpuDone) begin
          state_d = LDR_HALT;
        end
      end
      LDR_HALT: state_d = LDR_HALT;
      default:  state_d = LDR_IDLE;
    endcase
  end

  // State register; Rst discards any partial program.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= LDR_IDLE;
      wc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
    end
  end

  imem_array #(
    .D_WIDTH  (D_WIDTH),
    .SA_WIDTH (SA_WIDTH),
    .DEPTH    (DEPTH)
  ) u_array (
    .Clk       (Clk),
    .Rst       (Rst),
    .wr_en_i   (ld_hs),
    .wr_addr_i (wc_q[SA_WIDTH-1:0]),
    .wr_dat_i  (bus.LdData),
    .rd_en_i   (rd_en),
    .rd_clr_i  (rd_clr),
    .rd_addr_i (bus.Addr),
    .rd_dat_o  (bus.Data)
  );

  assign bus.LdReady   = ld_rdy;
  assign bus.CpuRst    = !run;
  assign bus.Busy      = ldr_busy(state_q);
  assign bus.Halted    = (state_q == LDR_HALT);
  assign bus.Err       = err_q;
  assign bus.WordCount = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a behavioural model checked every cycle.
// Inputs change 1 time unit after the rising edge; outputs compared on the falling edge.
// Literal expectations at key points pin the model itself.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  imem_loader_if #(.D_WIDTH(DW), .SA_WIDTH(AW)) bus ();

  imem_loader #(.D_WIDTH(DW), .SA_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: program content, how many words are in, whether the program is closed,
  // how many edges have passed since closing (0 = start cycle), halted, error, data.
  logic [31:0] m_mem [DEPTH];
  int          m_cnt;
  bit          m_done;
  int          m_age;
  bit          m_halted;
  bit          m_err;
  logic [31:0] m_data;
  bit          m_valid = 1'b0;
  bit          m_running;
  bit          m_hs;

  always @(posedge Clk) begin
    if (Rst) begin
      m_cnt = 0; m_done = 0; m_age = 0; m_halted = 0; m_err = 0; m_data = '0;
      m_valid = 1'b1;
    end else begin
      m_running = m_done && (m_age >= 1) && !m_halted;
      m_hs = bus.LdValid && !m_done && (m_cnt < DEPTH);
      if (m_done && m_age == 0) m_age = 1;
      if (m_hs) begin
        m_mem[m_cnt] = bus.LdData;
        m_cnt++;
        if (bus.LdLast || m_cnt == DEPTH) begin
          m_done = 1; m_age = 0;
          if (!bus.LdLast) m_err = 1;
        end
      end
      if (m_running) begin
        if (bus.En && !bus.RW) m_data = (int'(bus.Addr) < m_cnt) ? m_mem[bus.Addr] : 32'h0;
        if (bus.En && bus.RW) m_err = 1;
        if (bus.CpuDone) m_halted = 1;
      end else begin
        m_data = '0;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("LdReady",   32'(bus.LdReady),   32'(!m_done && m_cnt < DEPTH));
      chk("CpuRst",    32'(bus.CpuRst),    32'(!(m_done && m_age >= 1 && !m_halted)));
      chk("Busy",      32'(bus.Busy),      32'(m_done ? !m_halted : (m_cnt > 0)));
      chk("Halted",    32'(bus.Halted),    32'(m_halted));
      chk("Err",       32'(bus.Err),       32'(m_err));
      chk("WordCount", 32'(bus.WordCount), 32'(m_cnt));
      chk("Data",      bus.Data,           m_data);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  logic [31:0] prog [3];

  initial begin
    prog[0] = 32'h20010005; prog[1] = 32'h20020003; prog[2] = 32'h00221820;
    bus.LdValid = 0; bus.LdData = '0; bus.LdLast = 0;
    bus.Addr = '0; bus.En = 0; bus.RW = 0; bus.CpuDone = 0;

    // Reset values.
    do_reset();
    chk("rst_wc", 32'(bus.WordCount), 32'd0);
    chk("rst_ldready", 32'(bus.LdReady), 32'd1);
    chk("rst_cpurst", 32'(bus.CpuRst), 32'd1);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_data", bus.Data, 32'd0);

    // Three-word program.
    for (int i = 0; i < 3; i++) begin
      bus.LdValid = 1; bus.LdData = prog[i]; bus.LdLast = (i == 2);
      tick();
    end
    bus.LdValid = 0; bus.LdLast = 0;
    chk("ld3_wc", 32'(bus.WordCount), 32'd3);
    chk("ld3_ldready", 32'(bus.LdReady), 32'd0);
    chk("start_cpurst", 32'(bus.CpuRst), 32'd1);
    tick();
    chk("run_cpurst", 32'(bus.CpuRst), 32'd0);

    // Fetches.
    bus.En = 1; bus.RW = 0; bus.Addr = 5'd1;
    tick();
    chk("fetch1", bus.Data, 32'h20020003);
    bus.Addr = 5'd7;
    tick();
    chk("fetch_oob", bus.Data, 32'h0);
    bus.Addr = 5'd0; bus.RW = 1;
    tick();
    chk("wr_err", 32'(bus.Err), 32'd1);
    chk("wr_hold", bus.Data, 32'h0);
    bus.RW = 0;
    tick();
    chk("fetch0_after_wr", bus.Data, 32'h20010005);

    // Done together with a fetch: fetch served, then halt.
    bus.Addr = 5'd2; bus.CpuDone = 1;
    tick();
    bus.CpuDone = 0; bus.En = 0;
    chk("halt_halted", 32'(bus.Halted), 32'd1);
    chk("halt_busy", 32'(bus.Busy), 32'd0);
    chk("halt_cpurst", 32'(bus.CpuRst), 32'd1);
    chk("halt_fetch", bus.Data, 32'h00221820);
    repeat (3) tick();
    chk("halt_held", 32'(bus.Halted), 32'd1);
    chk("halt_data0", bus.Data, 32'h0);

    // Fill the whole array with no final-word marker.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      bus.LdValid = 1; bus.LdData = 32'hA0000000 + 32'(i); bus.LdLast = 0;
      tick();
    end
    chk("fill_err", 32'(bus.Err), 32'd1);
    chk("fill_wc", 32'(bus.WordCount), 32'd32);
    chk("fill_ldready", 32'(bus.LdReady), 32'd0);
    repeat (3) tick();
    bus.LdValid = 0;
    chk("fill_wc_stays", 32'(bus.WordCount), 32'd32);
    chk("fill_run", 32'(bus.CpuRst), 32'd0);
    bus.En = 1; bus.Addr = 5'd31;
    tick();
    chk("fill_fetch31", bus.Data, 32'hA000001F);
    bus.En = 0;

    // Reset in the middle of a load.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.LdValid = 1; bus.LdData = 32'h5000 + 32'(i); bus.LdLast = 0;
      tick();
    end
    bus.LdValid = 0;
    chk("part_wc", 32'(bus.WordCount), 32'd2);
    do_reset();
    chk("abort_wc", 32'(bus.WordCount), 32'd0);
    chk("abort_ldready", 32'(bus.LdReady), 32'd1);
    chk("abort_err", 32'(bus.Err), 32'd0);
    chk("abort_busy", 32'(bus.Busy), 32'd0);

    // One-word program reaches RUN.
    bus.LdValid = 1; bus.LdData = 32'h12345678; bus.LdLast = 1;
    tick();
    bus.LdValid = 0; bus.LdLast = 0;
    chk("one_start", 32'(bus.CpuRst), 32'd1);
    tick();
    chk("one_run", 32'(bus.CpuRst), 32'd0);
    bus.En = 1; bus.Addr = 5'd0;
    tick();
    chk("one_fetch0", bus.Data, 32'h12345678);
    bus.Addr = 5'd1;
    tick();
    chk("one_fetch_stale", bus.Data, 32'h0);
    bus.En = 0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory stage directly upstream of the GPP core.
- Accepts a program as a valid/ready word stream from the host or testbench and stores it in an internal word array.
- Holds the GPP in reset while loading, then releases it and serves its fetches (Addr/En/RW in, Data out) with 1-cycle registered latency.
- Watches the core's Done, then parks in a halted state and reports status.

Parameters:
- D_WIDTH, 32, instruction/data word width (same as `D_WIDTH`).
- SA_WIDTH, 5, fetch address width (same as `SA_WIDTH`).
- DEPTH, 32, number of words stored; must be ≤ 2**SA_WIDTH.

Ports:
- Clk  in  1  clock.
- Rst  in  1  synchronous, active-high reset.
- LdValid  in  1  load word present.
- LdData  in  D_WIDTH  load word.
- LdLast  in  1  qualifies LdData as the final program word.
- LdReady  out  1  loader can accept a word.
- Addr  in  SA_WIDTH  fetch address from the GPP.
- En  in  1  memory access enable from the GPP.
- RW  in  1  access type: 0 read, 1 write.
- Data  out  D_WIDTH  fetched word to the GPP, registered.
- CpuRst  out  1  reset to the GPP core, active-high.
- CpuDone  in  1  Done from the GPP.
- WordCount  out  SA_WIDTH+1  number of words loaded.
- Busy  out  1  loading, starting or running.
- Halted  out  1  program finished.
- Err  out  1  sticky protocol error.

Behaviour:
- Rst is synchronous and active-high; Clk is the clock.
- On Rst:
  - State=IDLE, WordCount=0, Data=0, CpuRst=1, Busy=0, Halted=0, Err=0.
  - LdReady=1 in the first cycle after reset.
  - Array contents are not cleared.
- Rst asserted mid-load or mid-run aborts immediately to the reset values above; the partial program is discarded (WordCount=0).
- Handshake: a word is accepted on a rising Clk edge when LdValid && LdReady.
  - The word is written to mem[WordCount], then WordCount increments.
  - LdData/LdLast are ignored when there is no handshake.
- LdReady = 1 in IDLE and LOAD while WordCount < DEPTH; 0 in every other state.
- States:
  - IDLE: CpuRst=1, Busy=0. Handshake with LdLast=0 → LOAD. Handshake with LdLast=1 → START (1-word program).
  - LOAD: CpuRst=1, Busy=1. Handshake with LdLast=1 → START. A handshake that fills the array (WordCount becomes DEPTH) without LdLast → START, and Err is set.
  - START: exactly 1 cycle. CpuRst=1, Busy=1. Gives the GPP's synchronous reset a clock edge. → RUN.
  - RUN: CpuRst=0, Busy=1. Serves fetches. CpuDone=1 sampled → HALT.
  - HALT: CpuRst=1, Busy=0, Halted=1. Stays until Rst.
- Read port, RUN only:
  - En=1 and RW=0 at edge N → Data = mem[Addr] after edge N, so it is valid during cycle N+1 (GPP decode cycle).
  - Addr ≥ WordCount → Data = 0 (sll r0,r0,0, a no-op).
  - En=0 → Data holds its last value.
  - Outside RUN, Data holds 0.
- In RUN, En=1 and RW=1 (write attempt): no array change, Data holds, Err set.
- LdValid outside IDLE/LOAD: ignored, no error.
- In the same cycle, CpuDone has priority over a fetch: the fetch is still served, and the state becomes HALT.
- Err is sticky until Rst.
- WordCount is SA_WIDTH+1 bits so that DEPTH=2**SA_WIDTH is representable; there is no wrap-around.

Decomposition:
- Shared include `define.h` gains:
  - LDR_IDLE=0, LDR_LOAD=1, LDR_START=2, LDR_RUN=3, LDR_HALT=4 (3-bit state codes).
  - IMEM_DEPTH.
  - `D_WIDTH` and `SA_WIDTH` are reused.
- One sub-module, imem_array: DEPTH×D_WIDTH, 1 synchronous write port, 1 registered read port.
- imem_loader contains the FSM, counter, address-range check and error logic, and instantiates imem_array.

Test Plan:
- Load 3 words 0x20010005, 0x20020003, 0x00221820 (LdLast on the 3rd).
  - Expect WordCount=3, LdReady=0 from the next cycle, CpuRst high through START and low 2 cycles after the last handshake.
- In RUN, drive Addr=1, En=1, RW=0.
  - Expect Data=0x20020003 in the following cycle.
  - Addr=7 (≥ WordCount) → Data=0.
- Load DEPTH=32 words with no LdLast.
  - Expect auto-transition to START and Err=1.
  - Further LdValid → LdReady stays 0 and WordCount stays 32.
- In RUN, drive En=1, RW=1, Addr=0.
  - Expect Err=1 and mem[0] unchanged (a later read of Addr=0 returns the original word).
- Assert CpuDone for 1 cycle in RUN.
  - Expect Halted=1, Busy=0, CpuRst=1 next cycle, held until Rst.
- Assert Rst after 2 of 5 load words.
  - Expect WordCount=0, state IDLE, LdReady=1, Err=0.
  - A fresh 1-word load with LdLast then reaches RUN.
